md_unit_sequencer: RTL and testbench

Multi-cycle multiply/divide unit with HI/LO registers for the 5-stage MIPS pipeline, sitting in the E stage beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo operations from E, models fixed execution latency with a busy counter, and commits HI/LO at completion. It drives the `Start`/`Busy` pair consumed by the stall controller, which holds any MD instruction in D while either is high. It suppresses new operations when an interrupt/exception request is raised.

---
 rtl/md_unit_sequencer.sv | 116 +++++++++++
 tb/tb_md_unit_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_sequencer.sv
// Multi-cycle multiply/divide sequencer with architectural HI/LO for the E stage.
// Result is computed at Start, held in pHI/pLO, and committed after a fixed Busy window.
module md_unit_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        Req,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_MDOut
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] p_hi, p_hi_nxt, p_lo, p_lo_nxt;
  logic [31:0] hi_nxt, lo_nxt;
  logic        commit_en, commit_en_nxt;

  logic        is_mul, is_div, is_signed;
  logic        a_neg, b_neg;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  assign is_mul    = (E_MDOp == 4'd1) || (E_MDOp == 4'd2);
  assign is_div    = (E_MDOp == 4'd3) || (E_MDOp == 4'd4);
  assign is_signed = (E_MDOp == 4'd1) || (E_MDOp == 4'd3);

  // Sign-extending into a 64-bit unsigned multiply yields the signed product in the low 64 bits.
  assign prod = {{32{is_signed & E_A[31]}}, E_A} * {{32{is_signed & E_B[31]}}, E_B};

  // Signed divide via magnitudes; also makes 0x80000000 / -1 wrap to 0x80000000 naturally.
  assign a_neg = is_signed & E_A[31];
  assign b_neg = is_signed & E_B[31];
  assign a_mag = a_neg ? (32'd0 - E_A) : E_A;
  assign b_mag = b_neg ? (32'd0 - E_B) : E_B;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign quo   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

  assign Busy    = (state == RUN);
  assign Start   = (is_mul || is_div) && !Busy && !Req;
  assign E_MDOut = (E_MDOp == 4'd7) ? HI : ((E_MDOp == 4'd8) ? LO : 32'd0);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    p_hi_nxt      = p_hi;
    p_lo_nxt      = p_lo;
    hi_nxt        = HI;
    lo_nxt        = LO;
    commit_en_nxt = commit_en;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt = RUN;
          if (is_mul) begin
            p_hi_nxt      = prod[63:32];
            p_lo_nxt      = prod[31:0];
            cnt_nxt       = 4'(MULT_CYCLES);
            commit_en_nxt = 1'b1;
          end else begin
            p_hi_nxt      = rem;
            p_lo_nxt      = quo;
            cnt_nxt       = 4'(DIV_CYCLES);
            commit_en_nxt = (E_B != 32'd0);
          end
        end else if (!Req) begin
          if (E_MDOp == 4'd5) hi_nxt = E_A;
          if (E_MDOp == 4'd6) lo_nxt = E_A;
        end
      end
      RUN: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = IDLE;
          if (commit_en) begin
            hi_nxt = p_hi;
            lo_nxt = p_lo;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      p_hi      <= 32'd0;
      p_lo      <= 32'd0;
      HI        <= 32'd0;
      LO        <= 32'd0;
      commit_en <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      p_hi      <= p_hi_nxt;
      p_lo      <= p_lo_nxt;
      HI        <= hi_nxt;
      LO        <= lo_nxt;
      commit_en <= commit_en_nxt;
    end
  end

endmodule

// File: tb/tb_md_unit_sequencer.sv
// Bench for md_unit_sequencer: hand-derived vector table, corner sequences, and random traffic
// checked every cycle against a remaining-cycles reference model.
module tb_md_unit_sequencer;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk, reset, Req, Start, Busy;
  logic [3:0]  E_MDOp;
  logic [31:0] E_A, E_B, HI, LO, E_MDOut;

  md_unit_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .E_MDOp(E_MDOp), .E_A(E_A), .E_B(E_B), .Req(Req),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .E_MDOut(E_MDOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;
  bit          m_ok;

  logic        s_start, s_busy;
  logic [31:0] s_hi, s_lo, s_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo, output bit ok);
    int sa, sb;
    longint sp;
    longint unsigned up, ua, ub;
    sa = a; sb = b; ua = a; ub = b;
    ok = 1'b1; hi = 32'd0; lo = 32'd0;
    case (op)
      4'd1: begin sp = longint'(sa) * longint'(sb); hi = sp[63:32]; lo = sp[31:0]; end
      4'd2: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      4'd3: begin
        if (b == 32'd0) ok = 1'b0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = 32'd0; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      4'd4: begin
        if (b == 32'd0) ok = 1'b0;
        else begin lo = a / b; hi = a % b; end
      end
      default: ok = 1'b0;
    endcase
  endfunction

  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic rq, input logic rs);
    bit e_busy, e_start;
    logic [31:0] e_out;
    @(negedge clk);
    E_MDOp = op; E_A = a; E_B = b; Req = rq; reset = rs;
    #1;
    s_start = Start; s_busy = Busy; s_hi = HI; s_lo = LO; s_out = E_MDOut;
    e_busy  = (m_left > 0);
    e_start = (op >= 4'd1 && op <= 4'd4) && !e_busy && !rq;
    e_out   = (op == 4'd7) ? m_hi : ((op == 4'd8) ? m_lo : 32'd0);
    if (chk_en) begin
      chk("model_start", {31'd0, s_start}, {31'd0, e_start});
      chk("model_busy",  {31'd0, s_busy},  {31'd0, e_busy});
      chk("model_hi",    s_hi,  m_hi);
      chk("model_lo",    s_lo,  m_lo);
      chk("model_mdout", s_out, e_out);
    end
    @(posedge clk);
    if (!rs) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_ok) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (!rq) begin
      if (op >= 4'd1 && op <= 4'd4) begin
        ref_calc(op, a, b, m_phi, m_plo, m_ok);
        m_left = (op <= 4'd2) ? MC : DC;
      end else if (op == 4'd5) m_hi = a;
      else if (op == 4'd6) m_lo = a;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        req;
    logic        st;
    int          cyc;
    logic [31:0] hi, lo;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int cycles;
    logic [3:0] rop;
    E_MDOp = 4'd0; E_A = 32'd0; E_B = 32'd0; Req = 1'b0; reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0; m_left = 0; m_ok = 1'b0;

    tbl[0]  = '{4'd1, 32'hFFFF_FFFF, 32'd2,          1'b0, 1'b1, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[1]  = '{4'd2, 32'hFFFF_FFFF, 32'd2,          1'b0, 1'b1, MC, 32'h0000_0001, 32'hFFFF_FFFE};
    tbl[2]  = '{4'd3, 32'hFFFF_FFF9, 32'd2,          1'b0, 1'b1, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3]  = '{4'd4, 32'd7,         32'd0,          1'b0, 1'b1, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[4]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF,  1'b0, 1'b1, DC, 32'h0000_0000, 32'h8000_0000};
    tbl[5]  = '{4'd5, 32'h1234_5678, 32'd0,          1'b0, 1'b0, 0,  32'h1234_5678, 32'h8000_0000};
    tbl[6]  = '{4'd6, 32'h0000_AAAA, 32'd0,          1'b1, 1'b0, 0,  32'h1234_5678, 32'h8000_0000};
    tbl[7]  = '{4'd1, 32'd3,         32'd3,          1'b1, 1'b0, 0,  32'h1234_5678, 32'h8000_0000};
    tbl[8]  = '{4'd6, 32'h0000_0055, 32'd0,          1'b0, 1'b0, 0,  32'h1234_5678, 32'h0000_0055};
    tbl[9]  = '{4'd2, 32'h0001_0000, 32'h0001_0000,  1'b0, 1'b1, MC, 32'h0000_0001, 32'h0000_0000};
    tbl[10] = '{4'd3, 32'd7,         32'hFFFF_FFFE,  1'b0, 1'b1, DC, 32'h0000_0001, 32'hFFFF_FFFD};
    tbl[11] = '{4'd12, 32'hDEAD_BEEF, 32'd1,         1'b0, 1'b0, 0,  32'h0000_0001, 32'hFFFF_FFFD};

    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("reset_busy", {31'd0, s_busy}, 32'd0);
    chk("reset_hi", s_hi, 32'd0);
    chk("reset_lo", s_lo, 32'd0);

    foreach (tbl[i]) begin
      step(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].req, 1'b1);
      chk($sformatf("tbl%0d_start", i), {31'd0, s_start}, {31'd0, tbl[i].st});
      cycles = 0;
      for (int k = 0; k < 40; k++) begin
        step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        if (!s_busy) break;
        cycles++;
      end
      chk($sformatf("tbl%0d_busy_cycles", i), cycles, tbl[i].cyc);
      chk($sformatf("tbl%0d_hi", i), s_hi, tbl[i].hi);
      chk($sformatf("tbl%0d_lo", i), s_lo, tbl[i].lo);
      step(4'd7, 32'd0, 32'd0, 1'b0, 1'b1);
      chk($sformatf("tbl%0d_mfhi", i), s_out, tbl[i].hi);
      step(4'd8, 32'd0, 32'd0, 1'b0, 1'b1);
      chk($sformatf("tbl%0d_mflo", i), s_out, tbl[i].lo);
    end

    // Back-to-back: multu enters E in the cycle right after the mult's Busy window.
    step(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
    for (int k = 0; k < MC; k++) begin
      step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      chk("b2b_busy1", {31'd0, s_busy}, 32'd1);
    end
    step(4'd2, 32'd3, 32'd4, 1'b0, 1'b1);
    chk("b2b_start", {31'd0, s_start}, 32'd1);
    chk("b2b_hi_visible", s_hi, 32'hFFFF_FFFF);
    for (int k = 0; k < MC; k++) begin
      step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      chk("b2b_busy2", {31'd0, s_busy}, 32'd1);
    end
    step(4'd8, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("b2b_done", {31'd0, s_busy}, 32'd0);
    chk("b2b_mflo", s_out, 32'd12);

    // Req toggling while a div is in flight must not stop its commit.
    step(4'd3, 32'd100, 32'd7, 1'b0, 1'b1);
    for (int k = 0; k < DC; k++) begin
      step(4'd0, 32'd0, 32'd0, (k % 3) == 1, 1'b1);
      chk("reqrun_busy", {31'd0, s_busy}, 32'd1);
    end
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("reqrun_done", {31'd0, s_busy}, 32'd0);
    chk("reqrun_hi", s_hi, 32'd2);
    chk("reqrun_lo", s_lo, 32'd14);

    // Reset in the third Busy cycle of a div aborts it.
    step(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("rstrun_busy", {31'd0, s_busy}, 32'd0);
    chk("rstrun_hi", s_hi, 32'd0);
    chk("rstrun_lo", s_lo, 32'd0);
    for (int k = 0; k < DC + 2; k++) step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("rstrun_no_commit_hi", s_hi, 32'd0);
    chk("rstrun_no_commit_lo", s_lo, 32'd0);

    for (int k = 0; k < 3000; k++) begin
      rop = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 19) == 0) rop = 4'($urandom_range(9, 15));
      step(rop, pick(), pick(), $urandom_range(0, 9) == 0, $urandom_range(0, 199) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
